// File: rtl/regbus_master_pkg.sv
// regbus_master_pkg
// Shared definitions for the demodulator register bus: FSM state encoding,
// bus widths and default bus-cycle timing. Imported by regbus_master.
package regbus_master_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_READ_WAIT     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RDWAIT = 3'd4,
    DONE   = 3'd5
  } regbusState_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/regbus_master.sv
// regbus_master
// Single initiator of the demodulator register bus. Accepts one valid/ready
// request at a time and runs the bus cycle: cs/addr/data setup, byte write
// strobes (responders commit on the strobe falling edge), hold, or a timed
// read of the responders' combinational read data. All outputs registered.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   reqValid/Ready   request handshake (ready only while idle)
//   reqWrite         1 = write, 0 = read
//   reqAddr/Data     request address and write data
//   reqByteEn        byte enables, bit n -> busWr[n], data[8n+7:8n]
//   rspValid/Data    one-cycle completion pulse; read data (held otherwise)
//   busCs/Addr/WrData/Wr  register bus outputs
//   busRdData        responder read data
module regbus_master
  import regbus_master_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int READ_WAIT     = DEF_READ_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  input  logic [BE_W-1:0]   reqByteEn,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              busCs,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWrData,
  output logic [BE_W-1:0]   busWr,
  input  logic [DATA_W-1:0] busRdData
);

  localparam int MAX_CYC = maxOf(maxOf(SETUP_CYCLES, STROBE_CYCLES),
                                 maxOf(HOLD_CYCLES, READ_WAIT));
  // Counter is loaded with N-1 and runs down to zero.
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] LOAD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_STROBE = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_HOLD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_READ   = CNT_W'(READ_WAIT - 1);

  regbusState_t      state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              isWrite, isWriteNext;
  logic [BE_W-1:0]   byteEn, byteEnNext;

  logic              reqReadyNext;
  logic              rspValidNext;
  logic [DATA_W-1:0] rspDataNext;
  logic              busCsNext;
  logic [ADDR_W-1:0] busAddrNext;
  logic [DATA_W-1:0] busWrDataNext;
  logic [BE_W-1:0]   busWrNext;

  logic              cntDone;
  assign cntDone = (cnt == '0);

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    isWriteNext   = isWrite;
    byteEnNext    = byteEn;
    rspValidNext  = 1'b0;
    rspDataNext   = rspData;
    busCsNext     = busCs;
    busAddrNext   = busAddr;
    busWrDataNext = busWrData;
    busWrNext     = busWr;

    unique case (state)
      IDLE: begin
        if (reqValid && reqReady) begin
          isWriteNext   = reqWrite;
          byteEnNext    = reqByteEn;
          busCsNext     = 1'b1;
          busAddrNext   = reqAddr;
          busWrDataNext = reqData;
          cntNext       = LOAD_SETUP;
          stateNext     = SETUP;
        end
      end
      SETUP: begin
        if (!cntDone) begin
          cntNext = cnt - CNT_W'(1);
        end else if (isWrite) begin
          busWrNext = byteEn;
          cntNext   = LOAD_STROBE;
          stateNext = STROBE;
        end else begin
          cntNext   = LOAD_READ;
          stateNext = RDWAIT;
        end
      end
      STROBE: begin
        if (!cntDone) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          busWrNext = '0;
          cntNext   = LOAD_HOLD;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (!cntDone) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          busCsNext    = 1'b0;
          rspValidNext = 1'b1;
          stateNext    = DONE;
        end
      end
      RDWAIT: begin
        if (!cntDone) begin
          cntNext = cnt - CNT_W'(1);
        end else begin
          // Sampled while cs is still high; cs drops on this same edge.
          rspDataNext  = busRdData;
          busCsNext    = 1'b0;
          rspValidNext = 1'b1;
          stateNext    = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        busCsNext = 1'b0;
        busWrNext = '0;
        stateNext = IDLE;
      end
    endcase

    // Registered ready: high exactly while the registered state is IDLE.
    reqReadyNext = (stateNext == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      isWrite   <= 1'b0;
      byteEn    <= '0;
      reqReady  <= 1'b1;
      rspValid  <= 1'b0;
      rspData   <= '0;
      busCs     <= 1'b0;
      busAddr   <= '0;
      busWrData <= '0;
      busWr     <= '0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      isWrite   <= isWriteNext;
      byteEn    <= byteEnNext;
      reqReady  <= reqReadyNext;
      rspValid  <= rspValidNext;
      rspData   <= rspDataNext;
      busCs     <= busCsNext;
      busAddr   <= busAddrNext;
      busWrData <= busWrDataNext;
      busWr     <= busWrNext;
    end
  end

endmodule
